// File: rtl/uart_bus_interface.sv
// ============================================================================
// uart_bus_interface: register-mapped host port for the UART TX/RX FIFO pair
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_bus_interface #(
  parameter int DATA_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sel,
  input  logic                 write_en,
  input  logic [1:0]           addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 ready,
  output logic                 tx_fifo_write,
  output logic [DATA_SIZE-1:0] tx_fifo_data,
  input  logic                 tx_fifo_full,
  input  logic                 tx_fifo_empty,
  output logic                 rx_fifo_write,
  output logic                 rx_fifo_read,
  input  logic [DATA_SIZE-1:0] rx_fifo_data,
  input  logic                 rx_fifo_full,
  input  logic                 rx_fifo_empty,
  input  logic                 rx_done,
  input  logic                 parity_error,
  input  logic                 stop_error,
  input  logic                 break_error,
  input  logic                 overflow_error,
  output logic                 irq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_ERR    = 2'd3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                        state;
  logic [SYNC_STAGES-1:0]        done_sync;
  logic [SYNC_STAGES-1:0][3:0]   flag_sync;
  logic                          done_prev;
  logic [2:0]                    ctrl;
  logic [7:0]                    err;
  logic                          done_pulse;
  logic                          bus_take;
  logic [7:0]                    err_set;
  logic [7:0]                    err_clr;
  logic [DATA_SIZE-1:0]          read_word;

  assign bus_take   = (state == IDLE) && sel;
  assign done_pulse = done_sync[SYNC_STAGES-1] & ~done_prev;

  always_comb begin
    err_set = 8'h00;
    err_clr = 8'h00;
    if (bus_take && (addr == ADDR_DATA)) begin
      if (write_en && tx_fifo_full)   err_set[5] = 1'b1;
      if (!write_en && rx_fifo_empty) err_set[6] = 1'b1;
    end
    if (bus_take && write_en && (addr == ADDR_ERR)) err_clr = wdata[7:0];
    if (done_pulse) begin
      err_set[3:0] = flag_sync[SYNC_STAGES-1];
      err_set[4]   = rx_fifo_full;
    end
  end

  always_comb begin
    read_word = '0;
    case (addr)
      ADDR_DATA:   read_word = rx_fifo_empty ? '0 : rx_fifo_data;
      ADDR_STATUS: read_word = DATA_SIZE'({|err, rx_fifo_empty, rx_fifo_full,
                                           tx_fifo_empty, tx_fifo_full});
      ADDR_CTRL:   read_word = DATA_SIZE'(ctrl);
      ADDR_ERR:    read_word = DATA_SIZE'(err);
      default:     read_word = '0;
    endcase
  end

  // Error flags share the rx_done synchronizer depth so they align with the pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_sync     <= '0;
      flag_sync     <= '0;
      done_prev     <= 1'b0;
      rx_fifo_write <= 1'b0;
    end else begin
      done_sync     <= {done_sync[SYNC_STAGES-2:0], rx_done};
      flag_sync     <= {flag_sync[SYNC_STAGES-2:0],
                        {overflow_error, break_error, stop_error, parity_error}};
      done_prev     <= done_sync[SYNC_STAGES-1];
      rx_fifo_write <= done_pulse & ~rx_fifo_full;
    end
  end

  // Set has priority over a same-cycle clear; bit 7 is never stored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 8'h00;
      irq <= 1'b0;
    end else begin
      err <= ((err & ~err_clr) | err_set) & 8'h7F;
      irq <= (ctrl[0] & tx_fifo_empty) | (ctrl[1] & ~rx_fifo_empty) | (ctrl[2] & (|err));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ready         <= 1'b0;
      rdata         <= '0;
      tx_fifo_write <= 1'b0;
      tx_fifo_data  <= '0;
      rx_fifo_read  <= 1'b0;
      ctrl          <= 3'b000;
    end else begin
      ready         <= 1'b0;
      tx_fifo_write <= 1'b0;
      rx_fifo_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (sel) begin
            state <= ACCESS;
            ready <= 1'b1;
            if (write_en) begin
              if ((addr == ADDR_DATA) && !tx_fifo_full) begin
                tx_fifo_write <= 1'b1;
                tx_fifo_data  <= wdata;
              end
              if (addr == ADDR_CTRL) ctrl <= wdata[2:0];
            end else begin
              rdata <= read_word;
              if ((addr == ADDR_DATA) && !rx_fifo_empty) rx_fifo_read <= 1'b1;
            end
          end
        end
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_bus_interface.md
Name: uart_bus_interface

Overview:
Register-mapped host interface for the UART. It sits between the system bus and the TX/RX FIFO pair: it pushes host writes into the TX FIFO and pops the RX FIFO on host reads. It also generates the RX FIFO write strobe from the receiver's rx_done, replacing ad-hoc glue logic. It captures receiver error flags into sticky registers and drives a registered interrupt.

Parameters:
DATA_SIZE, 8, width of the UART data word and of the bus data path
SYNC_STAGES, 2, synchronizer depth for rx_done and the receiver error flags (minimum 2)

Ports:
clk  input  1  system clock; same clock as both FIFOs
reset_n  input  1  asynchronous active-low reset
sel  input  1  bus access request; held by the requester until ready
write_en  input  1  access is a write (qualified by sel)
addr  input  2  register address: 0 DATA, 1 STATUS, 2 CTRL, 3 ERR
wdata  input  DATA_SIZE  bus write data
rdata  output  DATA_SIZE  bus read data, registered
ready  output  1  one-cycle access-complete pulse
tx_fifo_write  output  1  TX FIFO push strobe
tx_fifo_data  output  DATA_SIZE  TX FIFO push data
tx_fifo_full  input  1  TX FIFO full
tx_fifo_empty  input  1  TX FIFO empty
rx_fifo_write  output  1  RX FIFO push strobe
rx_fifo_read  output  1  RX FIFO pop strobe
rx_fifo_data  input  DATA_SIZE  RX FIFO head word (valid whenever not empty)
rx_fifo_full  input  1  RX FIFO full
rx_fifo_empty  input  1  RX FIFO empty
rx_done  input  1  receiver frame-done level, sample_clk domain
parity_error, stop_error, break_error, overflow_error  input  1 each  receiver flags, sample_clk domain
irq  output  1  registered interrupt

Behaviour:
- Reset: rdata=0, ready=0, all strobes=0, irq=0, CTRL=0, ERR=0, FSM=IDLE, synchronizers=0.
- FSM IDLE -> ACCESS when sel=1. ACCESS -> IDLE unconditionally. ready=1 only in ACCESS. Throughput is at most one access per 2 cycles. Side effects and rdata are produced on the IDLE->ACCESS edge, so ready and rdata are coincident, with rdata valid 1 cycle after sel is sampled.
- DATA write: if tx_fifo_full=0, tx_fifo_write=1 for exactly 1 cycle and tx_fifo_data=wdata. If full: no push, set ERR[5] tx_overrun.
- DATA read: if rx_fifo_empty=0, rdata=rx_fifo_data and rx_fifo_read=1 for 1 cycle. If empty: rdata=0, no pop, set ERR[6] rx_underrun.
- STATUS read returns {3'b0, |ERR, rx_fifo_empty, rx_fifo_full, tx_fifo_empty, tx_fifo_full} (bit 0 = tx_fifo_full). STATUS is read-only; writes are ignored and still acknowledged.
- CTRL is read/write, bits [2:0]: tx_ie, rx_ie, err_ie. Upper bits read 0.
- ERR read returns sticky bits: [0] parity, [1] stop, [2] break, [3] receiver overflow, [4] rx_drop, [5] tx_overrun, [6] rx_underrun, [7]=0. Writing 1 to a bit clears it. If a set and a clear of the same bit occur in the same cycle, the set wins.
- rx_done path: SYNC_STAGES-flop synchronizer, then rising-edge detect, giving a 1-cycle pulse per frame no matter how long rx_done stays high.
  - On the pulse, if rx_fifo_full=0, rx_fifo_write=1 for 1 cycle. If full: no write, set ERR[4] rx_drop.
  - On the same pulse, the synchronized error flags are OR-ed into ERR[3:0].
  - rx_fifo_write is independent of the bus FSM and may coincide with rx_fifo_read.
- irq is registered and equals (tx_ie & tx_fifo_empty) | (rx_ie & ~rx_fifo_empty) | (err_ie & |ERR). It updates 1 cycle after its inputs change.
- Reset mid-access: ready and strobes drop immediately (asynchronous). No partial push or pop survives.
- Addresses are fully decoded. sel with write_en=0 to CTRL/ERR has no side effects.

Test Plan:
- Reset, write DATA=0xB3 then DATA=0x5C with the TX FIFO not full -> two 1-cycle tx_fifo_write pulses carrying 0xB3, 0x5C; each ready exactly 1 cycle after sel is sampled; ERR=0.
- TX FIFO full, write DATA=0xAE -> no tx_fifo_write, ERR reads 0x20, STATUS bit4=1; write ERR=0x20 -> ERR reads 0x00.
- rx_done held high 40 cycles with rx_fifo_data=0xAE -> exactly one rx_fifo_write pulse, SYNC_STAGES+1 cycles after the rising edge. Read DATA -> rdata=0xAE, one rx_fifo_read pulse.
- rx_fifo_empty=1, read DATA -> rdata=0x00, no pop, ERR bit6 set. rx_done pulse with rx_fifo_full=1 and parity_error=1 -> no write, ERR=0x51.
- CTRL=0x02, RX FIFO goes non-empty -> irq=1 one cycle later. Pop until empty -> irq=0. CTRL=0x04 with ERR≠0 -> irq=1.
- Clear ERR bit0 in the same cycle as a new parity-flagged rx_done pulse -> ERR bit0 remains 1. Assert reset_n=0 during ACCESS -> ready and strobes go 0 immediately; all registers read reset values afterwards.
